// File: rtl/rf_write_scheduler_pkg.sv
// Shared types and constants for the register-file write-port scheduler.
// Holds the sizing parameters, the scheduler state and requester identifiers.
package rf_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int PTR_W    = ADDR_W + 1;

    localparam logic [ADDR_W-1:0] ZERO_REG = {ADDR_W{1'b0}};

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } sched_state_e;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

    // x0 is hard-wired, so a write aimed at it is consumed without strobing WE3
    function automatic logic is_writable(input logic [ADDR_W-1:0] addr);
        return (addr != ZERO_REG);
    endfunction

endpackage

// File: rtl/rf_write_scheduler_if.sv
// Requester handshakes and register-file write port of the write scheduler.
// The master side is the requesters/register file, the slave side is the scheduler.
interface rf_write_scheduler_if;
    import rf_pkg::*;

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_wdata;
    logic              init_done;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        input  alu_ready, mem_ready,
        input  rf_we, rf_addr, rf_wdata, init_done
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        output alu_ready, mem_ready,
        output rf_we, rf_addr, rf_wdata, init_done
    );

endinterface

// File: rtl/rf_write_scheduler_rr_arbiter2.sv
// Two-input round-robin arbiter: ready is combinational, priority flips to the
// other requester after every handshake and holds when nothing is accepted.
module rr_arbiter2
    import rf_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic alu_valid,
    input  logic mem_valid,
    output logic alu_ready,
    output logic mem_ready,
    output logic alu_grant,
    output logic mem_grant
);

    req_id_e prio_q;
    req_id_e prio_d;

    // ready/grant generation and next-priority selection
    always_comb begin
        alu_ready = en & (~mem_valid | (prio_q == REQ_ALU));
        mem_ready = en & (~alu_valid | (prio_q == REQ_MEM));
        alu_grant = alu_valid & alu_ready;
        mem_grant = mem_valid & mem_ready;
        prio_d    = prio_q;
        if (alu_grant) begin
            prio_d = REQ_MEM;
        end else if (mem_grant) begin
            prio_d = REQ_ALU;
        end else begin
            prio_d = prio_q;
        end
    end

    // priority register
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= REQ_ALU;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/rf_write_scheduler.sv
// Owns the register-file write port: zeroes x1..x31 after reset, then
// forwards round-robin arbitrated ALU/load writebacks through registered outputs.
module rf_write_scheduler
    import rf_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    rf_write_scheduler_if.slave  bus
);

    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_END = PTR_W'(NUM_REGS);

    sched_state_e      state_q,     state_d;
    logic [PTR_W-1:0]  clear_ptr_q, clear_ptr_d;
    logic              rf_we_q,     rf_we_d;
    logic [ADDR_W-1:0] rf_addr_q,   rf_addr_d;
    logic [DATA_W-1:0] rf_wdata_q,  rf_wdata_d;
    logic              init_done_q, init_done_d;

    logic run_s;
    logic alu_grant_s;
    logic mem_grant_s;

    assign run_s = (state_q == RUN);

    rr_arbiter2 u_arb (
        .clk       (clock),
        .reset     (reset),
        .en        (run_s),
        .alu_valid (bus.alu_valid),
        .mem_valid (bus.mem_valid),
        .alu_ready (bus.alu_ready),
        .mem_ready (bus.mem_ready),
        .alu_grant (alu_grant_s),
        .mem_grant (mem_grant_s)
    );

    // next-state and write-port computation for the clear sweep and run phase
    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        rf_we_d     = 1'b0;
        rf_addr_d   = rf_addr_q;
        rf_wdata_d  = rf_wdata_q;
        init_done_d = init_done_q;
        case (state_q)
            CLEAR: begin
                if (clear_ptr_q == PTR_END) begin
                    rf_we_d     = 1'b0;
                    init_done_d = 1'b1;
                    state_d     = RUN;
                end else begin
                    rf_we_d     = 1'b1;
                    rf_addr_d   = clear_ptr_q[ADDR_W-1:0];
                    rf_wdata_d  = {DATA_W{1'b0}};
                    clear_ptr_d = clear_ptr_q + PTR_ONE;
                end
            end
            RUN: begin
                if (alu_grant_s) begin
                    rf_we_d    = is_writable(bus.alu_addr);
                    rf_addr_d  = bus.alu_addr;
                    rf_wdata_d = bus.alu_data;
                end else if (mem_grant_s) begin
                    rf_we_d    = is_writable(bus.mem_addr);
                    rf_addr_d  = bus.mem_addr;
                    rf_wdata_d = bus.mem_data;
                end else begin
                    rf_we_d    = 1'b0;
                end
            end
            default: begin
                state_d     = CLEAR;
                clear_ptr_d = PTR_ONE;
                rf_we_d     = 1'b0;
                init_done_d = 1'b0;
            end
        endcase
    end

    // state and registered write-port outputs; reset discards any accepted write
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= CLEAR;
            clear_ptr_q <= PTR_ONE;
            rf_we_q     <= 1'b0;
            rf_addr_q   <= {ADDR_W{1'b0}};
            rf_wdata_q  <= {DATA_W{1'b0}};
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
            rf_we_q     <= rf_we_d;
            rf_addr_q   <= rf_addr_d;
            rf_wdata_q  <= rf_wdata_d;
            init_done_q <= init_done_d;
        end
    end

    assign bus.rf_we     = rf_we_q;
    assign bus.rf_addr   = rf_addr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Scoreboard bench for rf_write_scheduler: a cycle model predicts readies and
// queues the expected write-port contents, which are popped one edge later.
module tb_rf_write_scheduler;
    import rf_pkg::*;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              init;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    exp_t sb[$];

    bit                m_run;
    int                m_ptr;
    bit                m_prio;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    logic              m_init;

    rf_write_scheduler_if bus();

    rf_write_scheduler dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push(input logic we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic init);
        exp_t e;
        e.we = we; e.addr = a; e.data = d; e.init = init;
        sb.push_back(e);
        m_addr = a;
        m_data = d;
        m_init = init;
    endtask

    // One clock cycle: predict, check readies, clock, check the write port
    task automatic tick();
        logic er_a, er_m;
        exp_t e;
        #1;
        if (rst) begin
            m_run  = 1'b0;
            m_ptr  = 1;
            m_prio = 1'b0;
            push(1'b0, 5'd0, 32'd0, 1'b0);
        end else if (!m_run) begin
            chk("alu_ready_clear", {31'd0, bus.alu_ready}, 32'd0);
            chk("mem_ready_clear", {31'd0, bus.mem_ready}, 32'd0);
            if (m_ptr <= 31) begin
                push(1'b1, m_ptr[ADDR_W-1:0], 32'd0, 1'b0);
                m_ptr++;
            end else begin
                m_run = 1'b1;
                push(1'b0, m_addr, m_data, 1'b1);
            end
        end else begin
            er_a = ~bus.mem_valid | (m_prio == 1'b0);
            er_m = ~bus.alu_valid | (m_prio == 1'b1);
            chk("alu_ready", {31'd0, bus.alu_ready}, {31'd0, er_a});
            chk("mem_ready", {31'd0, bus.mem_ready}, {31'd0, er_m});
            if (bus.alu_valid && er_a) begin
                push(bus.alu_addr != 5'd0, bus.alu_addr, bus.alu_data, 1'b1);
                m_prio = 1'b1;
            end else if (bus.mem_valid && er_m) begin
                push(bus.mem_addr != 5'd0, bus.mem_addr, bus.mem_data, 1'b1);
                m_prio = 1'b0;
            end else begin
                push(1'b0, m_addr, m_data, 1'b1);
            end
        end
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("rf_we",     {31'd0, bus.rf_we},     {31'd0, e.we});
            chk("rf_addr",   {27'd0, bus.rf_addr},   {27'd0, e.addr});
            chk("rf_wdata",  bus.rf_wdata,           e.data);
            chk("init_done", {31'd0, bus.init_done}, {31'd0, e.init});
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0; bus.alu_addr = 5'd0; bus.alu_data = 32'd0;
        bus.mem_valid = 1'b0; bus.mem_addr = 5'd0; bus.mem_data = 32'd0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_run = 1'b0; m_ptr = 1; m_prio = 1'b0;
        m_addr = 5'd0; m_data = 32'd0; m_init = 1'b0;
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        tick();
        rst = 1'b0;

        // 1: sweep with both requesters asserting valid
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd4; bus.alu_data = 32'h0000_0044;
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd6; bus.mem_data = 32'h0000_0066;
        for (int i = 0; i < 32; i++) tick();
        idle_inputs();
        tick();

        // 2: single ALU write
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd5; bus.alu_data = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
        tick();
        tick();

        // 4: load to x0 is consumed without a write and hands priority to ALU
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd0; bus.mem_data = 32'h0000_1234;
        tick();
        idle_inputs();
        tick();

        // 3: both requesters held for four cycles
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd3; bus.alu_data = 32'hA1A1_0003;
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd7; bus.mem_data = 32'hB2B2_0007;
        for (int i = 0; i < 4; i++) tick();
        idle_inputs();
        tick();
        tick();

        // 5: reset in the middle of a sweep, when rf_addr shows 12
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 33; i++) tick();

        // 6: reset on the cycle an ALU write is accepted
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd9; bus.alu_data = 32'hCAFE_F00D;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        for (int i = 0; i < 33; i++) tick();

        // random traffic after the final sweep
        for (int i = 0; i < 40; i++) begin
            if (!bus.alu_valid || bus.alu_ready) begin
                bus.alu_valid = 1'($urandom_range(0, 1));
                bus.alu_addr  = 5'($urandom_range(0, 31));
                bus.alu_data  = $urandom;
            end
            if (!bus.mem_valid || bus.mem_ready) begin
                bus.mem_valid = 1'($urandom_range(0, 1));
                bus.mem_addr  = 5'($urandom_range(0, 31));
                bus.mem_data  = $urandom;
            end
            tick();
        end
        idle_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
